// File: rtl/cycle_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer_pkg
// Brief    : Addressing-mode / sequencer-state types and opcode length helpers
// Revision : 1.0 - initial release
// ============================================================================
package cycle_sequencer_pkg;

    typedef enum logic [3:0] {
        IND_X = 4'd0,
        ZP    = 4'd1,
        IMM   = 4'd2,
        ABS   = 4'd3,
        IND_Y = 4'd4,
        ZP_X  = 4'd5,
        ABS_Y = 4'd6,
        ABS_X = 4'd7,
        IMPL  = 4'd8
    } addr_mode_t;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    localparam logic [2:0] OP_STA_GRP    = 3'b100;
    localparam logic [2:0] C_IMPL_LEN_DF = 3'd2;

    function automatic addr_mode_t mode_of(input logic [7:0] ir);
        addr_mode_t m;
        if (ir[1:0] != 2'b01) begin
            m = IMPL;
        end else begin
            case (ir[4:2])
                3'b000:  m = IND_X;
                3'b001:  m = ZP;
                3'b010:  m = IMM;
                3'b011:  m = ABS;
                3'b100:  m = IND_Y;
                3'b101:  m = ZP_X;
                3'b110:  m = ABS_Y;
                default: m = ABS_X;
            endcase
        end
        return m;
    endfunction

    // Implied-group length is a block parameter; this value is only the fallback.
    function automatic logic [2:0] base_len(input addr_mode_t m);
        logic [2:0] n;
        case (m)
            IND_X:   n = 3'd6;
            ZP:      n = 3'd3;
            IMM:     n = 3'd2;
            ABS:     n = 3'd4;
            IND_Y:   n = 3'd5;
            ZP_X:    n = 3'd4;
            ABS_Y:   n = 3'd4;
            ABS_X:   n = 3'd4;
            default: n = C_IMPL_LEN_DF;
        endcase
        return n;
    endfunction

endpackage : cycle_sequencer_pkg
`default_nettype wire

// File: rtl/cycle_sequencer_opcode_mode_decode.sv
`default_nettype none
// ============================================================================
// Module   : opcode_mode_decode
// Brief    : Combinational opcode -> addressing mode, base length, store/index
// Revision : 1.0 - initial release
// ============================================================================
module opcode_mode_decode
    import cycle_sequencer_pkg::*;
#(
    parameter int IMPL_LEN = 2
) (
    input  logic [7:0]  IR,
    output addr_mode_t  mode,
    output logic [2:0]  len,
    output logic        is_store,
    output logic        is_indexed
);

    always_comb begin
        mode       = mode_of(IR);
        len        = (mode == IMPL) ? 3'(IMPL_LEN) : base_len(mode);
        is_store   = (IR[7:5] == OP_STA_GRP);
        is_indexed = (mode == IND_Y) || (mode == ABS_Y) || (mode == ABS_X);
    end

endmodule : opcode_mode_decode
`default_nettype wire

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_sequencer
// Brief    : Drives T-state advance/reset, fetch strobe, PC increment and R/W
// Revision : 1.0 - initial release
// ============================================================================
module cycle_sequencer
    import cycle_sequencer_pkg::*;
#(
    parameter int CYC_W    = 3,
    parameter int IMPL_LEN = 2
) (
    input  logic             clk_ph1,
    input  logic             rst,
    input  logic [7:0]       IR,
    input  logic [CYC_W-1:0] cycle,
    input  logic             rdy,
    input  logic             page_cross,
    output logic             inc_cycle,
    output logic             res_cycle,
    output logic             sync,
    output logic             pc_inc,
    output logic             rw
);

    localparam int C_CMP_W = ((CYC_W > 3) ? CYC_W : 3) + 1;

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic               r_extra_pend;
    logic               w_extra_pend_next;

    addr_mode_t         w_mode;
    logic [2:0]         w_len;
    logic               w_is_store;
    logic               w_is_indexed;

    logic [C_CMP_W-1:0] w_cyc;
    logic [C_CMP_W-1:0] w_n;
    logic [C_CMP_W-1:0] w_n_m1;
    logic [C_CMP_W-1:0] w_n_p1;
    logic               w_extend;
    logic               w_final;
    logic               w_desync;
    logic               w_abs_grp;

    opcode_mode_decode #(
        .IMPL_LEN   (IMPL_LEN)
    ) u_decode (
        .IR         (IR),
        .mode       (w_mode),
        .len        (w_len),
        .is_store   (w_is_store),
        .is_indexed (w_is_indexed)
    );

    always_ff @(posedge clk_ph1 or negedge rst) begin
        if (!rst) begin
            r_state      <= BOOT;
            r_extra_pend <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_extra_pend <= w_extra_pend_next;
        end
    end

    always_comb begin
        w_cyc     = C_CMP_W'(cycle);
        w_n       = C_CMP_W'(w_len);
        w_n_m1    = w_n - C_CMP_W'(1);
        w_n_p1    = w_n + C_CMP_W'(1);
        w_extend  = w_is_indexed && (w_is_store || page_cross);
        w_final   = ((w_cyc == w_n_m1) && !w_is_indexed) ||
                    ((w_cyc == w_n_m1) && !w_is_store)   ||
                    ((w_cyc == w_n) && r_extra_pend);
        // cycle==N without a pending extra cycle would otherwise never complete
        w_desync  = ((w_cyc >= w_n) && !r_extra_pend) || (w_cyc > w_n_p1);
        w_abs_grp = (w_mode == ABS) || (w_mode == ABS_X) || (w_mode == ABS_Y);
    end

    always_comb begin
        w_state_next      = r_state;
        w_extra_pend_next = r_extra_pend;
        inc_cycle         = 1'b0;
        res_cycle         = 1'b0;
        sync              = 1'b0;
        pc_inc            = 1'b0;
        rw                = 1'b1;

        case (r_state)
            BOOT: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (cycle == '0) begin
                    sync      = 1'b1;
                    pc_inc    = rdy;
                    inc_cycle = rdy;
                end else begin
                    rw     = !(w_is_store && w_final);
                    pc_inc = rdy && (((w_cyc == C_CMP_W'(1)) && (w_mode != IMPL)) ||
                                     ((w_cyc == C_CMP_W'(2)) && w_abs_grp));
                    if (rdy) begin
                        if (w_desync) begin
                            res_cycle         = 1'b1;
                            w_extra_pend_next = 1'b0;
                        end else if (w_cyc == w_n_m1) begin
                            if (w_extend) begin
                                inc_cycle         = 1'b1;
                                w_extra_pend_next = 1'b1;
                            end else begin
                                res_cycle = 1'b1;
                            end
                        end else if ((w_cyc == w_n) && r_extra_pend) begin
                            res_cycle         = 1'b1;
                            w_extra_pend_next = 1'b0;
                        end else begin
                            inc_cycle = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_next = BOOT;
            end
        endcase
    end

endmodule : cycle_sequencer
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cycle_sequencer
// Brief    : Directed + random bench with an instruction-level length model
// Revision : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

    localparam int CYC_W    = 3;
    localparam int IMPL_LEN = 2;

    logic             clk_ph1;
    logic             rst;
    logic [7:0]       IR;
    logic [CYC_W-1:0] cyc;
    logic             rdy;
    logic             page_cross;
    logic             inc_cycle;
    logic             res_cycle;
    logic             sync;
    logic             pc_inc;
    logic             rw;

    int vectors     = 0;
    int miscompares = 0;

    cycle_sequencer #(
        .CYC_W      (CYC_W),
        .IMPL_LEN   (IMPL_LEN)
    ) dut (
        .clk_ph1    (clk_ph1),
        .rst        (rst),
        .IR         (IR),
        .cycle      (cyc),
        .rdy        (rdy),
        .page_cross (page_cross),
        .inc_cycle  (inc_cycle),
        .res_cycle  (res_cycle),
        .sync       (sync),
        .pc_inc     (pc_inc),
        .rw         (rw)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Instruction-controller T-state counter
    always @(posedge clk_ph1 or negedge rst) begin
        if (!rst)           cyc <= '0;
        else if (res_cycle) cyc <= '0;
        else if (inc_cycle) cyc <= cyc + 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".inc"},  32'(inc_cycle), 32'd0);
        check({tag, ".res"},  32'(res_cycle), 32'd0);
        check({tag, ".sync"}, 32'(sync),      32'd0);
        check({tag, ".pc"},   32'(pc_inc),    32'd0);
        check({tag, ".rw"},   32'(rw),        32'd1);
    endtask

    // Instruction-level view: total T-states, operand fetch count, store flag
    function automatic void model(input logic [7:0] ir_v, input logic pc_v,
                                  output int len, output int ops, output bit st);
        int lens[8] = '{6, 3, 2, 4, 5, 4, 4, 4};
        int b;
        b  = int'(ir_v[4:2]);
        st = (ir_v[7:5] == 3'b100);
        if (ir_v[1:0] != 2'b01) begin
            len = IMPL_LEN;
            ops = 0;
        end else begin
            len = lens[b];
            ops = (b == 3 || b == 6 || b == 7) ? 2 : 1;
            if ((b == 4 || b == 6 || b == 7) && (st || pc_v)) len++;
        end
    endfunction

    // Entered and left at posedge+1 with the counter at 0.
    task automatic run_instr(input string tag, input logic [7:0] ir_v, input logic pc_v,
                             input int stall_at, input int stall_len, input bit rand_rdy);
        int  len, ops, clocks, stalled, ec;
        bit  st, done, r;
        model(ir_v, pc_v, len, ops, st);
        IR = ir_v;
        page_cross = pc_v;
        clocks = 0; stalled = 0; ec = 0; done = 0;
        while (!done && clocks < 64) begin
            if (rand_rdy)                                 r = ($urandom_range(0, 3) != 0);
            else if (ec == stall_at && stalled < stall_len) r = 1'b0;
            else                                          r = 1'b1;
            if (!r) stalled++;
            rdy = r;
            @(negedge clk_ph1);
            check({tag, ".cycle"}, 32'(cyc),       32'(ec));
            check({tag, ".sync"},  32'(sync),      32'(ec == 0));
            check({tag, ".pc"},    32'(pc_inc),    32'(r && (ec <= ops)));
            check({tag, ".inc"},   32'(inc_cycle), 32'(r && (ec < len - 1)));
            check({tag, ".res"},   32'(res_cycle), 32'(r && (ec == len - 1)));
            check({tag, ".rw"},    32'(rw),        32'(!(st && ec == len - 1)));
            @(posedge clk_ph1);
            #1;
            clocks++;
            if (r) begin
                if (ec == len - 1) done = 1'b1;
                else               ec++;
            end
        end
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".wrap"}, 32'(cyc),  32'd0);
        if (!rand_rdy) check({tag, ".clocks"}, 32'(clocks), 32'(len + stall_len));
    endtask

    initial begin
        rst = 1'b0; IR = 8'hA9; rdy = 1'b1; page_cross = 1'b0;
        repeat (2) @(posedge clk_ph1);
        #1;
        check_idle("reset");
        rst = 1'b1;
        @(negedge clk_ph1);
        check_idle("boot");
        check("boot.cycle", 32'(cyc), 32'd0);
        @(posedge clk_ph1);
        #1;

        run_instr("lda_imm",   8'hA9, 1'b0, -1, 0, 1'b0);
        run_instr("lda_abs",   8'hAD, 1'b0, -1, 0, 1'b0);
        run_instr("lda_absx1", 8'hBD, 1'b1, -1, 0, 1'b0);
        run_instr("lda_absx0", 8'hBD, 1'b0, -1, 0, 1'b0);
        run_instr("sta_absx",  8'h9D, 1'b0, -1, 0, 1'b0);
        run_instr("lda_indx",  8'hA1, 1'b0,  2, 3, 1'b0);

        // Abandon STA abs at cycle 3 with an asynchronous reset
        IR = 8'h8D; rdy = 1'b1; page_cross = 1'b0;
        repeat (3) @(posedge clk_ph1);
        #1;
        check("midrst.pre_cycle", 32'(cyc), 32'd3);
        rst = 1'b0;
        #1;
        check_idle("midrst");
        check("midrst.cycle", 32'(cyc), 32'd0);
        @(posedge clk_ph1);
        #1;
        rst = 1'b1;
        @(negedge clk_ph1);
        check_idle("midrst_boot");
        @(posedge clk_ph1);
        #1;
        run_instr("post_rst", 8'h8D, 1'b0, -1, 0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            run_instr("rand", 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), -1, 0, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_cycle_sequencer
`default_nettype wire
